// File: rtl/game_engine_fsm_if.sv
// ---------------------------------------------------------------------------
// game_engine_fsm_if
// Command/response bundle between the button/direction decoder (master) and
// the 2048 move engine (slave). The renderer taps grid/score/win/lose.
//   move_valid/move_dir/move_ready : one move per handshake
//   new_game, load_valid/load_grid : board commands, sampled while idle
//   grid, score, moved, done, win, lose : engine results
// ---------------------------------------------------------------------------
interface game_engine_fsm_if #(
  parameter int N  = 4,
  parameter int TW = 4
);
  logic              move_valid;
  logic [1:0]        move_dir;
  logic              move_ready;
  logic              new_game;
  logic              load_valid;
  logic [N*N*TW-1:0] load_grid;
  logic [N*N*TW-1:0] grid;
  logic [31:0]       score;
  logic              moved;
  logic              done;
  logic              win;
  logic              lose;

  modport master (
    output move_valid, move_dir, new_game, load_valid, load_grid,
    input  move_ready, grid, score, moved, done, win, lose
  );

  modport slave (
    input  move_valid, move_dir, new_game, load_valid, load_grid,
    output move_ready, grid, score, moved, done, win, lose
  );
endinterface

// File: rtl/game_engine_fsm.sv
// ---------------------------------------------------------------------------
// game_engine_fsm
// Multi-cycle 2048 engine for an N x N board of exponent-coded tiles
// (0 = blank, e = tile 2^e). A move slides/merges one line per cycle, then
// spawns one tile (1 or 2) in a random blank only if the board changed.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : game_engine_fsm_if.slave (commands in, board/score/flags out);
//          tile (r,c) sits at grid[(r*N+c)*TW +: TW], row 0 top, col 0 left
// ---------------------------------------------------------------------------
module game_engine_fsm #(
  parameter int          N       = 4,
  parameter int          TW      = 4,
  parameter int          WIN_EXP = 11,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  game_engine_fsm_if.slave bus
);

  localparam int              NN       = N * N;
  localparam int              LW       = (N > 1) ? $clog2(N) : 1;
  localparam int              CW       = $clog2(NN + 1);
  localparam logic [TW-1:0]   TILE_MAX = '1;
  localparam logic [33:0]     GAIN_CAP = 34'h1_0000_0000;
  localparam logic [15:0]     SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [2:0] {S_IDLE, S_SLIDE, S_COUNT, S_PLACE, S_CHECK} state_t;
  typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1,
                            DIR_UP    = 2'd2, DIR_DOWN = 2'd3} dir_t;

  // Registered state
  state_t        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [TW-1:0] board_q [NN];
  logic [31:0]   score_q;
  logic          moved_q, done_q, win_q, win_clr_q, lose_q;
  dir_t          dir_q;
  logic [LW-1:0] line_q;
  logic [CW-1:0] spawn_k_q;
  logic [TW-1:0] spawn_v_q;

  // Combinational helpers
  logic [15:0]   lfsr_next;
  logic          move_ready_c, cmd_new, cmd_load, cmd_move, last_line;
  logic [TW-1:0] line_in  [N];
  logic [TW-1:0] line_out [N];
  logic [TW-1:0] comp     [N+1];   // compacted line; extra slot is always blank
  int            comp_n, out_n;
  logic          skip;
  logic [33:0]   line_gain, score_sum;
  logic [31:0]   score_sat;
  logic          line_changed;
  logic [CW-1:0] blank_cnt, seen;
  logic [NN-1:0] place_sel;
  logic          has_pair, hit_win;
  int            p0, p1;

  // Position of the j-th tile of line i, j = 0 being the tile on the move edge.
  function automatic int tile_idx(dir_t d, int i, int j);
    case (d)
      DIR_LEFT:  return i * N + j;
      DIR_RIGHT: return i * N + (N - 1 - j);
      DIR_UP:    return j * N + i;
      default:   return (N - 1 - j) * N + i;
    endcase
  endfunction

  // Score contribution of a merge producing exponent e, capped at 2^32.
  function automatic logic [33:0] merge_term(logic [TW-1:0] e);
    if (int'(e) >= 32) return GAIN_CAP;
    return 34'd1 << e;
  endfunction

  // Galois LFSR, x^16 + x^14 + x^13 + x^11, shifting right.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign last_line = (line_q == LW'(N - 1));

  // -------------------------------------------------------------------------
  // FSM: next state and command decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    state_d      = state_q;
    move_ready_c = 1'b0;
    cmd_new      = 1'b0;
    cmd_load     = 1'b0;
    cmd_move     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        move_ready_c = 1'b1;
        if (bus.new_game) begin
          cmd_new = 1'b1;
          state_d = S_CHECK;
        end else if (bus.load_valid) begin
          cmd_load = 1'b1;
          state_d  = S_CHECK;
        end else if (bus.move_valid) begin
          cmd_move = 1'b1;
          state_d  = S_SLIDE;
        end
      end
      S_SLIDE: if (last_line) state_d = (moved_q || line_changed) ? S_COUNT : S_CHECK;
      S_COUNT: state_d = (blank_cnt == '0) ? S_CHECK : S_PLACE;
      S_PLACE: state_d = S_CHECK;
      S_CHECK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // One-line slide/merge for the line selected by line_q
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here on purpose: comp/out_n/skip are scratch
    // values consumed later in the same evaluation.
    for (int j = 0; j < N; j++) line_in[j] = board_q[tile_idx(dir_q, int'(line_q), j)];
    for (int j = 0; j <= N; j++) comp[j] = '0;
    comp_n = 0;
    for (int j = 0; j < N; j++) begin
      if (line_in[j] != '0) begin
        comp[comp_n] = line_in[j];
        comp_n       = comp_n + 1;
      end
    end
    for (int j = 0; j < N; j++) line_out[j] = '0;
    line_gain = '0;
    out_n     = 0;
    skip      = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (skip) begin
        skip = 1'b0;                       // partner already consumed by a merge
      end else if (comp[j] != '0) begin
        if (comp[j] == comp[j+1] && comp[j] != TILE_MAX) begin
          line_out[out_n] = comp[j] + TW'(1);
          line_gain       = line_gain + merge_term(comp[j] + TW'(1));
          if (line_gain > GAIN_CAP) line_gain = GAIN_CAP;
          skip = 1'b1;
        end else begin
          line_out[out_n] = comp[j];
        end
        out_n = out_n + 1;
      end
    end
    line_changed = 1'b0;
    for (int j = 0; j < N; j++) if (line_out[j] != line_in[j]) line_changed = 1'b1;
  end

  assign score_sum = {2'b00, score_q} + line_gain;
  assign score_sat = (score_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : score_sum[31:0];

  // -------------------------------------------------------------------------
  // Whole-board observations: blanks, spawn target, lose/win detection
  // -------------------------------------------------------------------------
  always_comb begin
    blank_cnt = '0;
    hit_win   = 1'b0;
    has_pair  = 1'b0;
    seen      = '0;
    place_sel = '0;
    for (int t = 0; t < NN; t++) begin
      if (board_q[t] == '0) begin
        if (seen == spawn_k_q) place_sel[t] = 1'b1;
        seen      = seen + CW'(1);
        blank_cnt = blank_cnt + CW'(1);
      end
      if (int'(board_q[t]) >= WIN_EXP) hit_win = 1'b1;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N - 1; c++)
        if (board_q[r*N+c] == board_q[r*N+c+1]) has_pair = 1'b1;
    for (int r = 0; r < N - 1; r++)
      for (int c = 0; c < N; c++)
        if (board_q[r*N+c] == board_q[(r+1)*N+c]) has_pair = 1'b1;
  end

  // Starting tiles for a new game; a collision moves the second one along.
  always_comb begin
    p0 = int'(lfsr_q) % NN;
    p1 = int'(lfsr_q[15:8]) % NN;
    if (p1 == p0) p1 = (p0 + 1) % NN;
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the board is a register array, not a RAM, so it is reset in full;
      // grid must read 0 while rst is low and a reset drops any partial move.
      for (int t = 0; t < NN; t++) board_q[t] <= '0;
      lfsr_q    <= SEED_EFF;
      score_q   <= '0;
      moved_q   <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      win_clr_q <= 1'b0;
      lose_q    <= 1'b0;
      dir_q     <= DIR_RIGHT;
      line_q    <= '0;
      spawn_k_q <= '0;
      spawn_v_q <= '0;
    end else begin
      lfsr_q <= lfsr_next;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_new) begin
            for (int t = 0; t < NN; t++) board_q[t] <= (t == p0 || t == p1) ? TW'(1) : '0;
            score_q   <= '0;
            win_clr_q <= 1'b1;
          end else if (cmd_load) begin
            for (int t = 0; t < NN; t++) board_q[t] <= bus.load_grid[t*TW +: TW];
            score_q   <= '0;
            win_clr_q <= 1'b1;
          end else if (cmd_move) begin
            dir_q   <= dir_t'(bus.move_dir);
            moved_q <= 1'b0;
            line_q  <= '0;
          end
        end
        S_SLIDE: begin
          for (int j = 0; j < N; j++) board_q[tile_idx(dir_q, int'(line_q), j)] <= line_out[j];
          score_q <= score_sat;
          moved_q <= moved_q | line_changed;
          line_q  <= line_q + LW'(1);
        end
        S_COUNT: begin
          if (blank_cnt != '0) begin
            spawn_k_q <= CW'(int'(lfsr_q) % int'(blank_cnt));
            spawn_v_q <= (lfsr_q[3:0] == 4'h0) ? TW'(2) : TW'(1);
          end
        end
        S_PLACE: begin
          for (int t = 0; t < NN; t++) if (place_sel[t]) board_q[t] <= spawn_v_q;
        end
        S_CHECK: begin
          // win is cleared by new_game/load here, so both flags move together.
          lose_q    <= (blank_cnt == '0) && !has_pair;
          win_q     <= (win_q && !win_clr_q) || hit_win;
          win_clr_q <= 1'b0;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NN; g++) begin : g_grid
    assign bus.grid[g*TW +: TW] = board_q[g];
  end

  assign bus.move_ready = move_ready_c;
  assign bus.score      = score_q;
  assign bus.moved      = moved_q;
  assign bus.done       = done_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;

endmodule

// File: tb/tb_game_engine_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_engine_fsm
// Drives game_engine_fsm through its bus interface with directed boards and
// random loads/moves, comparing against a rotate-and-slide-left board model.
// ---------------------------------------------------------------------------
module tb_game_engine_fsm;

  localparam int          N       = 4;
  localparam int          TW      = 4;
  localparam int          NN      = N * N;
  localparam int          WIN_EXP = 11;
  localparam int          MAXE    = 15;
  localparam logic [15:0] SEED    = 16'hACE1;

  typedef int board_t [NN];

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_engine_fsm_if #(.N(N), .TW(TW)) bus ();

  game_engine_fsm #(.N(N), .TW(TW), .WIN_EXP(WIN_EXP), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state
  board_t      m_tile;
  longint      m_score;
  bit          m_win;
  bit          m_lose;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_step(logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [15:0] lfsr_adv(logic [15:0] x, int k);
    logic [15:0] y = x;
    for (int i = 0; i < k; i++) y = lfsr_step(y);
    return y;
  endfunction

  // Free-running copy of the engine's random source.
  always @(posedge clk or negedge rst)
    if (!rst) lfsr_m <= SEED;
    else      lfsr_m <= lfsr_step(lfsr_m);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(board_t b);
    logic [63:0] g = '0;
    for (int t = 0; t < NN; t++) g[t*TW +: TW] = 4'(b[t]);
    return g;
  endfunction

  task automatic unpack(input logic [63:0] g, output board_t b);
    for (int t = 0; t < NN; t++) b[t] = int'(g[t*TW +: TW]);
  endtask

  function automatic int count_tiles(logic [63:0] g, int v);
    int n = 0;
    for (int t = 0; t < NN; t++)
      if ((v < 0) ? (g[t*TW +: TW] != 0) : (int'(g[t*TW +: TW]) == v)) n++;
    return n;
  endfunction

  function automatic bit differ(board_t a, board_t b);
    for (int t = 0; t < NN; t++) if (a[t] != b[t]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic rot_cw(input board_t a, output board_t o);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) o[r*N+c] = a[(N-1-c)*N + r];
  endtask

  // Rotate so the move becomes "left", slide rows left, rotate back.
  task automatic model_move(input int dir, input board_t a, output board_t o, output longint gain);
    board_t t;
    int k;
    k = (dir == 0) ? 2 : (dir == 1) ? 0 : (dir == 2) ? 3 : 1;
    t = a;
    for (int i = 0; i < k; i++) rot_cw(t, t);
    gain = 0;
    for (int r = 0; r < N; r++) begin
      int q[$];
      int res[$];
      for (int c = 0; c < N; c++) if (t[r*N+c] != 0) q.push_back(t[r*N+c]);
      while (q.size() > 0) begin
        if (q.size() > 1 && q[0] == q[1] && q[0] != MAXE) begin
          res.push_back(q[0] + 1);
          gain += longint'(1) << (q[0] + 1);
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          res.push_back(q.pop_front());
        end
      end
      for (int c = 0; c < N; c++) t[r*N+c] = (c < res.size()) ? res[c] : 0;
    end
    for (int i = 0; i < (4 - k) % 4; i++) rot_cw(t, t);
    o = t;
  endtask

  function automatic void model_flags(bit clear_win);
    int blanks = 0;
    bit pair = 1'b0;
    bit big = 1'b0;
    for (int t = 0; t < NN; t++) begin
      if (m_tile[t] == 0) blanks++;
      if (m_tile[t] >= WIN_EXP) big = 1'b1;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (c + 1 < N && m_tile[r*N+c] == m_tile[r*N+c+1]) pair = 1'b1;
        if (r + 1 < N && m_tile[r*N+c] == m_tile[(r+1)*N+c]) pair = 1'b1;
      end
    m_lose = (blanks == 0) && !pair;
    m_win  = (m_win && !clear_win) || big;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_grid"}, bus.grid, pack(m_tile));
    check({tag, "_score"}, 64'(bus.score), 64'(m_score));
    check({tag, "_win"}, 64'(bus.win), 64'(m_win));
    check({tag, "_lose"}, 64'(bus.lose), 64'(m_lose));
  endtask

  // Wait for done (bounded); noise pokes commands while the engine is busy.
  task automatic wait_done(input string tag, input int exp_lat, input bit noise);
    int lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) begin
        bus.load_valid = 1'b0;
        bus.new_game   = 1'b0;
      end
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (noise && cyc == 1) begin
        bus.load_valid = 1'b1;
        bus.new_game   = 1'b1;
        bus.load_grid  = {$urandom, $urandom};
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ready"}, 64'(bus.move_ready), 64'd1);
  endtask

  task automatic pulse_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic do_move(input int dir, input bit noise);
    board_t post;
    longint gain;
    logic [15:0] l0, lc;
    bit changed;
    int blanks, k, v, seen;
    @(negedge clk);
    l0 = lfsr_m;
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'(dir);
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'($urandom);
    check("move_busy", 64'(bus.move_ready), 64'd0);
    model_move(dir, m_tile, post, gain);
    changed = differ(post, m_tile);
    if (changed) begin
      lc = lfsr_adv(l0, N + 1);
      blanks = 0;
      for (int t = 0; t < NN; t++) if (post[t] == 0) blanks++;
      if (blanks > 0) begin
        k = int'(lc) % blanks;
        v = (lc[3:0] == 4'h0) ? 2 : 1;
        seen = 0;
        for (int t = 0; t < NN; t++)
          if (post[t] == 0) begin
            if (seen == k) post[t] = v;
            seen++;
          end
      end
    end
    m_tile  = post;
    m_score = (m_score + gain > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_score + gain;
    model_flags(1'b0);
    wait_done("move", changed ? N + 3 : N + 1, noise);
    check("move_moved", 64'(bus.moved), 64'(changed));
    check_model("move");
    pulse_check("move");
  endtask

  task automatic do_load(input logic [63:0] g);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_grid  = g;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    unpack(g, m_tile);
    m_score = 0;
    model_flags(1'b1);
    wait_done("load", 1, 1'b0);
    check_model("load");
  endtask

  task automatic do_new_game();
    logic [15:0] l0;
    int p0, p1;
    @(negedge clk);
    l0 = lfsr_m;
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    p0 = int'(l0) % NN;
    p1 = int'(l0[15:8]) % NN;
    if (p1 == p0) p1 = (p0 + 1) % NN;
    for (int t = 0; t < NN; t++) m_tile[t] = 0;
    m_tile[p0] = 1;
    m_tile[p1] = 1;
    m_score = 0;
    model_flags(1'b1);
    wait_done("new", 1, 1'b0);
    check_model("new");
  endtask

  function automatic logic [63:0] rand_grid();
    logic [63:0] g = '0;
    int x;
    for (int t = 0; t < NN; t++) begin
      x = $urandom_range(0, 19);
      if (x < 8)       g[t*TW +: TW] = 4'd0;
      else if (x < 18) g[t*TW +: TW] = 4'($urandom_range(1, 4));
      else             g[t*TW +: TW] = 4'($urandom_range(10, 15));
    end
    return g;
  endfunction

  initial begin
    board_t probe;
    longint pg;
    int still_dir;
    logic [63:0] chk;

    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    bus.new_game   = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_grid  = '0;
    for (int t = 0; t < NN; t++) m_tile[t] = 0;
    m_score = 0;
    m_win   = 1'b0;
    m_lose  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_grid", bus.grid, 64'd0);
    check("rst_score", 64'(bus.score), 64'd0);
    check("rst_flags", {60'd0, bus.moved, bus.done, bus.win, bus.lose}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(bus.move_ready), 64'd1);

    // Empty board: nothing moves, nothing spawns
    do_move($urandom_range(0, 3), 1'b0);

    // Four equal tiles merge pairwise
    do_load(64'h0000_0000_0000_1111);
    do_move(1, 1'b0);
    check("t1_score", 64'(bus.score), 64'd8);
    check("t1_row0", 64'(bus.grid[7:0]), 64'h22);
    check("t1_tiles", 64'(count_tiles(bus.grid, -1)), 64'd3);

    // A merged tile does not merge again
    do_load(64'h0000_0000_0000_0211);
    do_move(1, 1'b1);
    check("t2_score", 64'(bus.score), 64'd4);
    check("t2_row0", 64'(bus.grid[7:0]), 64'h22);

    // Already-packed row: unchanged, no spawn
    do_load(64'h0000_0000_0000_0021);
    do_move(1, 1'b0);
    check("t3_grid", bus.grid, 64'h21);
    check("t3_score", 64'(bus.score), 64'd0);

    // Full checkerboard: stuck, then a new game
    chk = '0;
    for (int t = 0; t < NN; t++) chk[t*TW +: TW] = (((t / N) + (t % N)) % 2 == 1) ? 4'd2 : 4'd1;
    do_load(chk);
    do_move($urandom_range(0, 3), 1'b0);
    check("t4_moved", 64'(bus.moved), 64'd0);
    check("t4_lose", 64'(bus.lose), 64'd1);
    do_new_game();
    check("t4_new_lose", 64'(bus.lose), 64'd0);
    check("t4_new_ones", 64'(count_tiles(bus.grid, 1)), 64'd2);
    check("t4_new_score", 64'(bus.score), 64'd0);

    // 1024+1024 wins; capped tiles stay apart
    do_load(64'h0000_0000_0000_FFAA);
    do_move(1, 1'b0);
    check("t5_row0", 64'(bus.grid[11:0]), 64'hFFB);
    check("t5_score", 64'(bus.score), 64'd2048);
    check("t5_win", 64'(bus.win), 64'd1);
    still_dir = 1;
    for (int d = 3; d >= 0; d--) begin
      model_move(d, m_tile, probe, pg);
      if (!differ(probe, m_tile)) still_dir = d;
    end
    do_move(still_dir, 1'b0);
    check("t5_win_sticky", 64'(bus.win), 64'd1);

    // Reset in the middle of a slide
    do_load(64'h0000_0000_0000_1111);
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd1;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_grid", bus.grid, 64'd0);
    check("mid_rst_score", 64'(bus.score), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_ready", 64'(bus.move_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.new_game = 1'b1;
    @(posedge clk); #1;
    bus.new_game = 1'b0;
    wait_done("seed_new", 1, 1'b0);
    // SEED 0xACE1: p0 = 0xACE1 % 16 = 1, p1 = 0xAC % 16 = 12
    check("seed_grid", bus.grid, 64'h0001_0000_0000_0010);
    for (int t = 0; t < NN; t++) m_tile[t] = (t == 1 || t == 12) ? 1 : 0;
    m_score = 0;
    m_win   = 1'b0;
    model_flags(1'b1);

    // Random play
    for (int it = 0; it < 12; it++) begin
      if (it % 4 == 3) do_new_game();
      else             do_load(rand_grid());
      for (int m = 0; m < 4; m++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_move($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
